// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues 1-cycle-latency reads to instruction
// memory, buffers returned words in a small FIFO and hands them to decode via valid/ready.
module fetch_unit #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            run,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [15:0]     out_instr,
    output logic [3:0]      out_op,
    output logic [1:0]      out_rs,
    output logic [1:0]      out_rt,
    output logic [1:0]      out_rd,
    output logic [7:0]      out_imm
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PC_W-1:0]  req_pc_q, req_pc_d;
    logic             inflight_q, inflight_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PC_W-1:0]  fifo_pc_q [DEPTH];
    logic [PC_W-1:0]  fifo_pc_d [DEPTH];
    logic [15:0]      fifo_instr_q [DEPTH];
    logic [15:0]      fifo_instr_d [DEPTH];

    logic             head_valid;
    logic             pop;
    logic             push;
    logic             issue;
    logic [CNT_W:0]   occupancy;

    // Occupancy counts the outstanding response so the buffer can never overflow.
    always_comb begin
        head_valid = (count_q != '0);
        pop        = head_valid & out_ready;
        push       = inflight_q & ~redirect_valid;
        occupancy  = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q} - {{CNT_W{1'b0}}, pop};
        issue      = run & ~redirect_valid & ~reset & (occupancy < (CNT_W+1)'(DEPTH));
    end

    always_comb begin
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        inflight_d   = issue;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        fifo_pc_d    = fifo_pc_q;
        fifo_instr_d = fifo_instr_q;

        if (issue) begin
            pc_d     = pc_q + 1'b1;
            req_pc_d = pc_q;
        end
        if (push) begin
            fifo_pc_d[wr_ptr_q]    = req_pc_q;
            fifo_instr_d[wr_ptr_q] = imem_rdata;
            wr_ptr_d               = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Flush wins over any same-cycle push/pop; the stale response is dropped.
        if (redirect_valid) begin
            pc_d       = redirect_pc;
            inflight_d = 1'b0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= RESET_PC;
            inflight_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc_q[i]    <= '0;
                fifo_instr_q[i] <= '0;
            end
        end else begin
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            inflight_q   <= inflight_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            fifo_pc_q    <= fifo_pc_d;
            fifo_instr_q <= fifo_instr_d;
        end
    end

    assign imem_req  = issue;
    assign imem_addr = pc_q;
    assign out_valid = head_valid;
    assign out_pc    = head_valid ? fifo_pc_q[rd_ptr_q]    : '0;
    assign out_instr = head_valid ? fifo_instr_q[rd_ptr_q] : '0;
    assign out_op    = out_instr[15:12];
    assign out_rs    = out_instr[11:10];
    assign out_rt    = out_instr[9:8];
    assign out_rd    = out_instr[7:6];
    assign out_imm   = out_instr[7:0];

    a_no_push_full: assert property (@(posedge clock) disable iff (reset)
        !(push && !pop && count_q == CNT_W'(DEPTH)));
    a_no_pop_empty: assert property (@(posedge clock) disable iff (reset)
        !(pop && count_q == '0));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, streaming, field split, backpressure,
// redirect, run-low drain, PC wrap and mid-stream reset.
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        run = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [7:0]  redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_pc;
    logic [15:0] out_instr;
    logic [3:0]  out_op;
    logic [1:0]  out_rs, out_rt, out_rd;
    logic [7:0]  out_imm;

    int checks = 0;
    int failures = 0;

    fetch_unit #(.PC_W(8), .RESET_PC(8'h00), .DEPTH(2)) dut (
        .clock(clock), .reset(reset), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_instr(out_instr), .out_op(out_op), .out_rs(out_rs), .out_rt(out_rt),
        .out_rd(out_rd), .out_imm(out_imm)
    );

    always #5 clock = ~clock;

    // Memory image: word = address, except 0x41 holds an addi for the field check.
    function automatic logic [15:0] mem_word(input logic [7:0] a);
        return (a == 8'h41) ? 16'h4A7F : {8'h00, a};
    endfunction

    always @(posedge clock) begin
        if (imem_req) imem_rdata <= mem_word(imem_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        @(negedge clock);
    endtask

    initial begin
        // Reset held with run=1
        run = 1'b1; out_ready = 1'b1;
        #1 reset = 1'b1;
        step(); step();
        mid();
        chk("rst_req",   imem_req,  0);
        chk("rst_valid", out_valid, 0);
        chk("rst_addr",  imem_addr, 8'h00);
        chk("rst_pc",    out_pc,    0);

        // Streaming from reset
        step(); reset = 1'b0;              // cycle 0
        mid();
        chk("c0_req",   imem_req,  1);
        chk("c0_addr",  imem_addr, 8'h00);
        chk("c0_valid", out_valid, 0);
        step(); mid();                     // cycle 1
        chk("c1_valid", out_valid, 0);
        chk("c1_addr",  imem_addr, 8'h01);
        for (int k = 2; k < 8; k++) begin
            step(); mid();
            chk("str_valid", out_valid, 1);
            chk("str_pc",    out_pc,    k - 2);
            chk("str_instr", out_instr, k - 2);
        end

        // Backpressure for 6 cycles, head is pc 6
        step(); out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            mid();
            chk("bp_valid", out_valid, 1);
            chk("bp_req",   imem_req,  0);
            chk("bp_pc",    out_pc,    8'h06);
            step();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            mid();
            chk("bp_res_valid", out_valid, 1);
            chk("bp_res_pc",    out_pc,    6 + k);
            step();
        end

        // Redirect with a buffered entry and a response in flight
        redirect_valid = 1'b1; redirect_pc = 8'h40; out_ready = 1'b0;
        mid();
        chk("rd_req", imem_req, 0);
        step(); redirect_valid = 1'b0; out_ready = 1'b1;
        mid();
        chk("rd_valid0", out_valid, 0);
        chk("rd_req1",   imem_req,  1);
        chk("rd_addr",   imem_addr, 8'h40);
        step(); mid();
        chk("rd_valid1", out_valid, 0);
        step(); mid();
        chk("rd_first_valid", out_valid, 1);
        chk("rd_first_pc",    out_pc,    8'h40);
        chk("rd_first_instr", out_instr, 16'h0040);
        step(); mid();
        chk("fs_pc",    out_pc,    8'h41);
        chk("fs_instr", out_instr, 16'h4A7F);
        chk("fs_op",    out_op,    4'b0100);
        chk("fs_rs",    out_rs,    2'b10);
        chk("fs_rt",    out_rt,    2'b10);
        chk("fs_rd",    out_rd,    2'b01);
        chk("fs_imm",   out_imm,   8'h7F);

        // run low: outstanding word still delivered, then nothing
        step(); run = 1'b0;
        mid();
        chk("run0_req", imem_req, 0);
        chk("run0_pc",  out_pc,   8'h42);
        step(); mid();
        chk("run0_req2",  imem_req,  0);
        chk("run0_valid", out_valid, 1);
        chk("run0_pc2",   out_pc,    8'h43);
        step(); mid();
        chk("run0_empty", out_valid, 0);
        chk("run0_req3",  imem_req,  0);

        // PC wrap
        step(); redirect_valid = 1'b1; redirect_pc = 8'hFF; run = 1'b1;
        step(); redirect_valid = 1'b0;
        mid();
        chk("wr_addr_ff", imem_addr, 8'hFF);
        chk("wr_req_ff",  imem_req,  1);
        step(); mid();
        chk("wr_addr_00", imem_addr, 8'h00);
        chk("wr_req_00",  imem_req,  1);
        step(); mid();
        chk("wr_pc_ff",    out_pc,    8'hFF);
        chk("wr_instr_ff", out_instr, 16'h00FF);
        step(); mid();
        chk("wr_pc_00", out_pc, 8'h00);
        chk("wr_v_00",  out_valid, 1);

        // Asynchronous reset mid-stream
        #1 reset = 1'b1;
        #1;
        chk("mr_valid", out_valid, 0);
        chk("mr_req",   imem_req,  0);
        chk("mr_addr",  imem_addr, 8'h00);
        step(); reset = 1'b0;
        mid();
        chk("mr_req1",   imem_req,  1);
        chk("mr_addr1",  imem_addr, 8'h00);
        chk("mr_valid1", out_valid, 0);
        step(); mid();
        chk("mr_valid2", out_valid, 0);
        step(); mid();
        chk("mr_valid3", out_valid, 1);
        chk("mr_pc3",    out_pc,    8'h00);
        chk("mr_instr3", out_instr, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
